// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: fetch FSM states, NOP encoding and the default
// reset PC used by the front-end.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        FULL,
        DROP
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/if_id_fetch_ctrl.sv
// Instruction-fetch controller feeding the IF/ID pipeline register, with a
// single outstanding imem request and stall/flush performance counters.
module if_id_fetch_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_write,
    input  logic             if_id_hold,
    input  logic             if_id_flush,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_valid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_instr,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  buffer;
    logic         advance;
    logic         unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign advance   = (state == FULL) & pc_write & if_id_hold & ~if_id_flush & ~redirect_valid;
    assign imem_req  = (state == ISSUE) & ~rst;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ISSUE;
            pc          <= RESET_PC;
            buffer      <= '0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else begin
            // Redirect outranks both stall and advance when choosing the next PC.
            if (redirect_valid) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end else if (advance) begin
                pc <= pc + 32'd4;
            end

            if (if_id_flush) begin
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end else if (advance) begin
                if_id_pc    <= pc;
                if_id_instr <= buffer;
                if_id_valid <= 1'b1;
            end

            case (state)
                ISSUE: state <= redirect_valid ? DROP : WAIT;
                WAIT: begin
                    // A response coinciding with a redirect is already the stale
                    // one, so drop it here rather than waiting in DROP forever.
                    if (imem_valid && redirect_valid) begin
                        state <= ISSUE;
                    end else if (imem_valid) begin
                        buffer <= imem_rdata;
                        state  <= FULL;
                    end else if (redirect_valid) begin
                        state <= DROP;
                    end
                end
                FULL: begin
                    if (redirect_valid || advance) begin
                        state <= ISSUE;
                    end
                end
                DROP: begin
                    if (imem_valid) begin
                        state <= ISSUE;
                    end
                end
                default: state <= ISSUE;
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~pc_write),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (if_id_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_if_id_fetch_ctrl.sv
// Directed bench for if_id_fetch_ctrl: fetch sequencing, stalls, flushes,
// redirects, reset during a fetch and counter saturation.
module tb_if_id_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic        if_id_hold;
    logic        if_id_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int total = 0;
    int bad   = 0;

    if_id_fetch_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_write       (pc_write),
        .if_id_hold     (if_id_hold),
        .if_id_flush    (if_id_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From ISSUE: let the request go out, answer one cycle later, end in FULL.
    task automatic fetch_into_full(input logic [31:0] instr);
        tick();
        imem_valid = 1'b1;
        imem_rdata = instr;
        tick();
        imem_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
        total++; if (if_id_instr !== 32'h0000_0013) begin bad++; $display("FAIL reset_instr: got %h want 00000013", if_id_instr); end
        total++; if (if_id_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", if_id_pc); end
        total++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt: got %h/%h want 0/0", stall_cnt, flush_cnt); end
        rst = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL first_req: got %b@%h want 1@00000000", imem_req, imem_addr); end
    endtask

    task automatic test_fetch();
        for (int k = 0; k < 3; k++) begin
            total++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin bad++; $display("FAIL fetch_req%0d: got %b@%h want 1@%h", k, imem_req, imem_addr, 32'(4 * k)); end
            tick();
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL fetch_wait%0d: got req %b want 0", k, imem_req); end
            imem_valid = 1'b1;
            imem_rdata = 32'h1000_0000 + 32'(k);
            tick();
            imem_valid = 1'b0;
            tick();
            total++; if (if_id_pc !== 32'(4 * k) || if_id_instr !== 32'h1000_0000 + 32'(k) || if_id_valid !== 1'b1) begin
                bad++; $display("FAIL fetch_ifid%0d: got %h/%h/%b want %h/%h/1", k, if_id_pc, if_id_instr, if_id_valid, 32'(4 * k), 32'h1000_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_stall();
        fetch_into_full(32'h1000_000c);
        tick();
        fetch_into_full(32'h2000_0010);
        pc_write   = 1'b0;
        if_id_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (imem_req !== 1'b0 || if_id_pc !== 32'h0000_000c || if_id_instr !== 32'h1000_000c || if_id_valid !== 1'b1) begin
                bad++; $display("FAIL stall_hold%0d: got req %b ifid %h/%h/%b want 0 0000000c/1000000c/1", i, imem_req, if_id_pc, if_id_instr, if_id_valid);
            end
        end
        pc_write   = 1'b1;
        if_id_hold = 1'b1;
        total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt); end
        tick();
        total++; if (if_id_pc !== 32'h0000_0010 || if_id_instr !== 32'h2000_0010) begin bad++; $display("FAIL stall_release: got %h/%h want 00000010/20000010", if_id_pc, if_id_instr); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0014) begin bad++; $display("FAIL stall_next_req: got %b@%h want 1@00000014", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        if_id_flush    = 1'b1;
        tick();
        redirect_valid = 1'b0;
        if_id_flush    = 1'b0;
        total++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0) begin bad++; $display("FAIL redir_drop: got req %b valid %b want 0 0", imem_req, if_id_valid); end
        total++; if (flush_cnt !== 16'd1) begin bad++; $display("FAIL redir_flush_cnt: got %0d want 1", flush_cnt); end
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL redir_drop_wait: got req %b want 0", imem_req); end
        imem_valid = 1'b1;
        imem_rdata = 32'hdead_beef;
        tick();
        imem_valid = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100 || if_id_valid !== 1'b0) begin
            bad++; $display("FAIL redir_reissue: got %b@%h valid %b want 1@00000100 valid 0", imem_req, imem_addr, if_id_valid);
        end
        fetch_into_full(32'h3000_0100);
        tick();
        total++; if (if_id_pc !== 32'h0000_0100 || if_id_instr !== 32'h3000_0100 || if_id_valid !== 1'b1) begin
            bad++; $display("FAIL redir_target: got %h/%h/%b want 00000100/30000100/1", if_id_pc, if_id_instr, if_id_valid);
        end
    endtask

    task automatic test_flush_over_hold();
        if_id_flush = 1'b1;
        if_id_hold  = 1'b0;
        tick();
        if_id_flush = 1'b0;
        if_id_hold  = 1'b1;
        total++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0000_0013 || if_id_pc !== 32'h0000_0100) begin
            bad++; $display("FAIL flush_hold: got %h/%h/%b want 00000100/00000013/0", if_id_pc, if_id_instr, if_id_valid);
        end
        total++; if (flush_cnt !== 16'd2) begin bad++; $display("FAIL flush_cnt: got %0d want 2", flush_cnt); end
    endtask

    task automatic test_reset_in_wait();
        rst = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rstwait_req: got %b want 0", imem_req); end
        tick();
        rst        = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 32'hbad0_bad0;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rstwait_reissue: got %b@%h want 1@00000000", imem_req, imem_addr); end
        total++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0 || if_id_valid !== 1'b0) begin
            bad++; $display("FAIL rstwait_clear: got %h/%h valid %b want 0/0 valid 0", stall_cnt, flush_cnt, if_id_valid);
        end
        tick();
        imem_valid = 1'b0;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rstwait_in_wait: got req %b want 0", imem_req); end
        imem_valid = 1'b1;
        imem_rdata = 32'h4000_0000;
        tick();
        imem_valid = 1'b0;
        tick();
        total++; if (if_id_pc !== 32'h0 || if_id_instr !== 32'h4000_0000 || if_id_valid !== 1'b1) begin
            bad++; $display("FAIL rstwait_ifid: got %h/%h/%b want 00000000/40000000/1", if_id_pc, if_id_instr, if_id_valid);
        end
    endtask

    task automatic test_redirect_stall();
        fetch_into_full(32'h5000_0004);
        pc_write       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0202;
        tick();
        redirect_valid = 1'b0;
        pc_write       = 1'b1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin bad++; $display("FAIL redir_stall_req: got %b@%h want 1@00000200", imem_req, imem_addr); end
        total++; if (if_id_pc !== 32'h0 || if_id_instr !== 32'h4000_0000) begin bad++; $display("FAIL redir_stall_ifid: got %h/%h want 00000000/40000000", if_id_pc, if_id_instr); end
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL redir_stall_cnt: got %0d want 1", stall_cnt); end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        pc_write = 1'b0;
        repeat (16'hfffe) tick();
        total++; if (stall_cnt !== 16'hfffe) begin bad++; $display("FAIL sat_pre: got %h want fffe", stall_cnt); end
        repeat (3) tick();
        total++; if (stall_cnt !== 16'hffff) begin bad++; $display("FAIL sat_top: got %h want ffff", stall_cnt); end
        tick();
        total++; if (stall_cnt !== 16'hffff) begin bad++; $display("FAIL sat_hold: got %h want ffff", stall_cnt); end
        pc_write = 1'b1;
    endtask

    initial begin
        rst            = 1'b1;
        pc_write       = 1'b1;
        if_id_hold     = 1'b1;
        if_id_flush    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_valid     = 1'b0;
        imem_rdata     = 32'h0;

        test_reset();
        test_fetch();
        test_stall();
        test_redirect_wait();
        test_flush_over_hold();
        test_reset_in_wait();
        test_redirect_stall();
        test_saturation();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
